// File: rtl/nr_mem_arbiter_if.sv
// rtl/nr_mem_arbiter_if.sv - requester and data-memory signal bundle for nr_mem_arbiter
interface nr_mem_arbiter_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
);
  logic              req0;
  logic              we0;
  logic [ADDR_W-1:0] adr0;
  logic [DATA_W-1:0] wdat0;
  logic              ack0;
  logic [DATA_W-1:0] rdat0;

  logic              req1;
  logic              we1;
  logic [ADDR_W-1:0] adr1;
  logic [DATA_W-1:0] wdat1;
  logic              ack1;
  logic [DATA_W-1:0] rdat1;

  logic [ADDR_W-1:0] m_adr;
  logic [DATA_W-1:0] m_wdat;
  logic              m_canWrt;
  logic              m_canRd;
  logic [DATA_W-1:0] m_rdat;

  logic [1:0]        gnt;
  logic              busy;

  // requesters and the memory instance
  modport master (
    output req0, we0, adr0, wdat0, req1, we1, adr1, wdat1, m_rdat,
    input  ack0, rdat0, ack1, rdat1, m_adr, m_wdat, m_canWrt, m_canRd, gnt, busy
  );

  // the arbiter
  modport slave (
    input  req0, we0, adr0, wdat0, req1, we1, adr1, wdat1, m_rdat,
    output ack0, rdat0, ack1, rdat1, m_adr, m_wdat, m_canWrt, m_canRd, gnt, busy
  );
endinterface

// File: rtl/nr_mem_arbiter.sv
// rtl/nr_mem_arbiter.sv - two-requester data-memory arbiter and sequencer
// Defining NR_ARB_FIXED_PRIO_EN gives requester 0 fixed priority instead of round-robin.
module nr_mem_arbiter #(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 4,
  parameter int MEM_LAT = 1
) (
  input logic             clk,
  input logic             clr,
  nr_mem_arbiter_if.slave bus
);
  localparam int CNT_W = $clog2(MEM_LAT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;

  state_t            state;
  state_t            state_nxt;
  logic              own;
  logic              pick;
  logic              any_req;
  logic              lat_we;
  logic [ADDR_W-1:0] lat_adr;
  logic [DATA_W-1:0] lat_wdat;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] rdat0_q;
  logic [DATA_W-1:0] rdat1_q;

  assign any_req = bus.req0 | bus.req1;

`ifdef NR_ARB_FIXED_PRIO_EN
  assign pick = ~bus.req0;
`else
  logic last;

  // on a tie the requester that was not served last wins
  assign pick = (bus.req0 & bus.req1) ? ~last : bus.req1;

  always_ff @(posedge clk or posedge clr) begin
    if (clr)
      last <= 1'b1;
    else if (state == ACK)
      last <= own;
  end
`endif

  always_ff @(posedge clk or posedge clr) begin
    if (clr)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    bus.m_adr    = '0;
    bus.m_wdat   = '0;
    bus.m_canWrt = 1'b0;
    bus.m_canRd  = 1'b0;
    bus.ack0     = 1'b0;
    bus.ack1     = 1'b0;
    case (state)
      IDLE: begin
        if (any_req)
          state_nxt = ISSUE;
      end
      ISSUE: begin
        bus.m_adr    = lat_adr;
        bus.m_wdat   = lat_wdat;
        bus.m_canWrt = lat_we;
        bus.m_canRd  = ~lat_we;
        state_nxt    = lat_we ? ACK : WAIT;
      end
      WAIT: begin
        if (cnt == CNT_W'(1))
          state_nxt = ACK;
      end
      ACK: begin
        bus.ack0  = ~own;
        bus.ack1  = own;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // request capture, latency counter and per-requester read-data holding registers
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      own      <= 1'b0;
      lat_we   <= 1'b0;
      lat_adr  <= '0;
      lat_wdat <= '0;
      cnt      <= '0;
      rdat0_q  <= '0;
      rdat1_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            own      <= pick;
            lat_we   <= pick ? bus.we1   : bus.we0;
            lat_adr  <= pick ? bus.adr1  : bus.adr0;
            lat_wdat <= pick ? bus.wdat1 : bus.wdat0;
          end
        end
        ISSUE: cnt <= CNT_W'(MEM_LAT);
        WAIT: begin
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            if (own)
              rdat1_q <= bus.m_rdat;
            else
              rdat0_q <= bus.m_rdat;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.gnt   = (state == IDLE) ? 2'b00 : {own, ~own};
  assign bus.busy  = (state != IDLE);
  assign bus.rdat0 = rdat0_q;
  assign bus.rdat1 = rdat1_q;
endmodule

// File: tb/tb_nr_mem_arbiter.sv
// tb/tb_nr_mem_arbiter.sv - randomized model-checked bench for nr_mem_arbiter at MEM_LAT 1 and 3
module tb_nr_mem_arbiter;
  logic clk = 1'b0;
  logic clr = 1'b0;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   mode = 0;  // 0 quiet, 1 random traffic, 2 both requesters held high

  logic       dir_we   [2] = '{1'b0, 1'b0};
  logic [3:0] dir_adr  [2] = '{4'h0, 4'h0};
  logic [7:0] dir_wdat [2] = '{8'h00, 8'h00};
  int         dir_seq  [2] = '{0, 0};
  event       rr_check;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [7:0] fill(input int i);
    return (i == 7) ? 8'h5C : 8'(i * 19 + 1);
  endfunction

  task automatic clr_pulse();
    @(posedge clk);
    #2 clr = 1'b1;
    @(posedge clk);
    #2 clr = 1'b0;
  endtask

  task automatic dir_req(input int r, input logic we, input logic [3:0] adr, input logic [7:0] wdat);
    dir_we[r]   = we;
    dir_adr[r]  = adr;
    dir_wdat[r] = wdat;
    dir_seq[r]  = dir_seq[r] + 1;
  endtask

  for (genvar g = 0; g < 2; g++) begin : lane
    localparam int LAT = (g == 0) ? 1 : 3;

    nr_mem_arbiter_if #(.DATA_W(8), .ADDR_W(4)) bus ();

    nr_mem_arbiter #(.DATA_W(8), .ADDR_W(4), .MEM_LAT(LAT)) dut (
      .clk (clk),
      .clr (clr),
      .bus (bus.slave)
    );

    // data memory: read data valid only in the LAT-th cycle after the read strobe, noise otherwise
    logic [7:0] mem [16];
    logic       pv  [LAT];
    logic [7:0] pd  [LAT];
    logic [7:0] junk;
    always @(posedge clk) begin
      junk <= 8'($urandom);
      if (clr) begin
        for (int i = 0; i < 16; i++) mem[i] <= fill(i);
        for (int i = 0; i < LAT; i++) pv[i] <= 1'b0;
      end else begin
        if (bus.m_canWrt) mem[bus.m_adr] <= bus.m_wdat;
        for (int i = LAT - 1; i > 0; i--) begin
          pv[i] <= pv[i-1];
          pd[i] <= pd[i-1];
        end
        pv[0] <= bus.m_canRd;
        pd[0] <= mem[bus.m_adr];
      end
    end
    assign bus.m_rdat = pv[LAT-1] ? pd[LAT-1] : junk;

    // requester agents
    logic       rq   [2] = '{1'b0, 1'b0};
    logic       wv   [2] = '{1'b0, 1'b0};
    logic [3:0] av   [2] = '{4'h0, 4'h0};
    logic [7:0] dv   [2] = '{8'h00, 8'h00};
    logic       hold [2] = '{1'b0, 1'b0};
    int         seen [2] = '{0, 0};
    int         taken[2] = '{0, 0};
    int         ack_cnt[2] = '{0, 0};
    bit         just;
    assign bus.req0 = rq[0]; assign bus.we0 = wv[0]; assign bus.adr0 = av[0]; assign bus.wdat0 = dv[0];
    assign bus.req1 = rq[1]; assign bus.we1 = wv[1]; assign bus.adr1 = av[1]; assign bus.wdat1 = dv[1];

    always @(posedge clk) begin
      #1;
      for (int r = 0; r < 2; r++) begin
        if (clr) begin
          rq[r] = 1'b0; hold[r] = 1'b0; seen[r] = ack_cnt[r];
        end else begin
          just = (seen[r] != ack_cnt[r]);
          seen[r] = ack_cnt[r];
          if (just) hold[r] = 1'b0;
          if (!hold[r]) begin
            rq[r] = 1'b0;
            if (!(just && mode != 2)) begin
              if (taken[r] != dir_seq[r]) begin
                taken[r] = dir_seq[r];
                hold[r] = 1'b1; rq[r] = 1'b1;
                wv[r] = dir_we[r]; av[r] = dir_adr[r]; dv[r] = dir_wdat[r];
              end else if (mode == 2 || (mode == 1 && $urandom_range(0, 2) == 0)) begin
                hold[r] = 1'b1; rq[r] = 1'b1;
                wv[r] = 1'($urandom); av[r] = 4'($urandom); dv[r] = 8'($urandom);
              end
            end
          end
        end
      end
    end

    // transaction-level reference: schedule of issue/ack cycles plus a shadow memory
    logic [7:0] ref_mem [16];
    logic [7:0] e_rdat  [2] = '{8'h00, 8'h00};
    bit         t_act = 1'b0;
    int         t_own, t_iss, t_ack;
    logic       t_we;
    logic [3:0] t_adr;
    logic [7:0] t_wdat;
    int         last_m = 1;
    int         d_served [512];
    int         n_d = 0;
    int         rr_base = 0;
    int         prev_mode = 0;
    bit         in_iss, in_ack;

    always @(negedge clk) begin
      if (mode == 2 && prev_mode != 2) rr_base = n_d;
      prev_mode = mode;
      if (bus.ack0 ^ bus.ack1) begin
        d_served[n_d % 512] = int'(bus.ack1);
        n_d++;
      end
      if (clr) begin
        t_act = 1'b0; last_m = 1; e_rdat[0] = 8'h00; e_rdat[1] = 8'h00;
        for (int i = 0; i < 16; i++) ref_mem[i] = fill(i);
        chk("clr_gnt", bus.gnt, 0);
        chk("clr_ack", {bus.ack1, bus.ack0}, 0);
        chk("clr_strobe", {bus.m_canWrt, bus.m_canRd}, 0);
        chk("clr_rdat", {bus.rdat1, bus.rdat0}, 0);
      end else begin
        in_iss = t_act && cyc == t_iss;
        in_ack = t_act && cyc == t_ack;
        if (in_ack) begin
          if (t_we) ref_mem[t_adr] = t_wdat;
          else e_rdat[t_own] = ref_mem[t_adr];
        end
        chk("gnt", bus.gnt, t_act ? 32'(1 << t_own) : 0);
        chk("busy", bus.busy, t_act);
        chk("m_adr", bus.m_adr, in_iss ? t_adr : 4'h0);
        chk("m_wdat", bus.m_wdat, in_iss ? t_wdat : 8'h00);
        chk("m_canWrt", bus.m_canWrt, in_iss && t_we);
        chk("m_canRd", bus.m_canRd, in_iss && !t_we);
        chk("ack0", bus.ack0, in_ack && t_own == 0);
        chk("ack1", bus.ack1, in_ack && t_own == 1);
        chk("rdat0", bus.rdat0, e_rdat[0]);
        chk("rdat1", bus.rdat1, e_rdat[1]);
        if (in_ack) begin
          ack_cnt[t_own]++;
          last_m = t_own;
          t_act = 1'b0;
        end else if (!t_act && (bus.req0 || bus.req1)) begin
`ifdef NR_ARB_FIXED_PRIO_EN
          t_own = bus.req0 ? 0 : 1;
`else
          t_own = (bus.req0 && bus.req1) ? 1 - last_m : (bus.req1 ? 1 : 0);
`endif
          t_we   = t_own == 1 ? bus.we1   : bus.we0;
          t_adr  = t_own == 1 ? bus.adr1  : bus.adr0;
          t_wdat = t_own == 1 ? bus.wdat1 : bus.wdat0;
          t_iss  = cyc + 1;
          t_ack  = cyc + 2 + (t_we ? 0 : LAT);
          t_act  = 1'b1;
        end
      end
    end

    // outputs must fall as soon as clr rises, ahead of any clock edge
    always @(posedge clr) begin
      #1;
      chk("clr_now_gnt", bus.gnt, 0);
      chk("clr_now_busy", bus.busy, 0);
      chk("clr_now_strobe", {bus.m_canWrt, bus.m_canRd}, 0);
      chk("clr_now_bus", {bus.m_adr, bus.m_wdat}, 0);
      chk("clr_now_ack", {bus.ack1, bus.ack0}, 0);
      chk("clr_now_rdat", {bus.rdat1, bus.rdat0}, 0);
    end

    always @(rr_check) begin
      chk("rr_count", 32'(n_d - rr_base >= 4), 1);
      for (int k = 0; k < 4; k++) begin
`ifdef NR_ARB_FIXED_PRIO_EN
        chk("rr_order", d_served[(rr_base + k) % 512], 0);
`else
        chk("rr_order", d_served[(rr_base + k) % 512], k % 2);
`endif
      end
    end
  end

  initial begin
    #3 clr = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #2 clr = 1'b0;

    @(negedge clk); dir_req(0, 1'b1, 4'h3, 8'hA5);
    repeat (8) @(posedge clk);
    @(negedge clk); dir_req(1, 1'b0, 4'h7, 8'h00);
    repeat (10) @(posedge clk);

    clr_pulse();
    mode = 2;
    repeat (30) @(posedge clk);
    mode = 0;
    repeat (20) @(posedge clk);
    -> rr_check;
    repeat (2) @(posedge clk);

    @(negedge clk); dir_req(0, 1'b0, 4'h5, 8'h00);
    repeat (3) @(posedge clk);
    #2 clr = 1'b1;
    @(posedge clk);
    #2 clr = 1'b0;
    @(negedge clk);
    dir_req(0, 1'b1, 4'h9, 8'h3C);
    dir_req(1, 1'b0, 4'h9, 8'h00);
    repeat (16) @(posedge clk);

    mode = 1;
    for (int i = 0; i < 6; i++) begin
      repeat ($urandom_range(200, 500)) @(posedge clk);
      clr_pulse();
      mode = (i == 2) ? 2 : 1;
    end
    repeat (300) @(posedge clk);
    mode = 0;
    repeat (20) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/nr_mem_arbiter.md
Name: nr_mem_arbiter

Overview:
Two-requester arbiter and sequencer for the single-port nanoRisk data memory (8-bit data, 4-bit address, separate write/read strobes).
- Requesters: the core load/store path and the I/O-loader path.
- Per transaction it captures the request, drives the memory strobes for one cycle, waits out the memory read latency, returns read data and pulses an acknowledge.
- Sits between the requesters and the data memory instance; it is the only driver of the memory's address, data and enable inputs.

Parameters:
DATA_W, 8, data width
ADDR_W, 4, address width
MEM_LAT, 1, memory read latency in cycles (>=1); number of WAIT cycles

Ports:
clk  in  1  clock; all state changes on rising edge
clr  in  1  reset, asynchronous, active-high; clears all state and outputs
req0  in  1  requester 0 request; held until ack0
we0  in  1  requester 0: 1=write, 0=read
adr0  in  ADDR_W  requester 0 address
wdat0  in  DATA_W  requester 0 write data
ack0  out  1  requester 0 done, one-cycle pulse
rdat0  out  DATA_W  requester 0 read data
req1, we1, adr1, wdat1, ack1, rdat1: same as above for requester 1
m_adr  out  ADDR_W  memory address
m_wdat  out  DATA_W  memory write data
m_canWrt  out  1  memory write enable
m_canRd  out  1  memory read enable
m_rdat  in  DATA_W  memory read data
gnt  out  2  one-hot current owner
busy  out  1  high when state != IDLE

Behaviour:
- Reset (clr=1, async):
  - state=IDLE; all outputs 0; internal latches 0; round-robin pointer last=1, so requester 0 has priority first.
  - Memory strobes drop immediately. Any in-flight transaction is aborted with no ack.
- States: IDLE, ISSUE, WAIT, ACK.
- IDLE:
  - No req: stay in IDLE.
  - One req: that requester wins.
  - Both req: the requester != last wins.
  - On winning: latch we/adr/wdat of the winner, set gnt, go to ISSUE.
- ISSUE (exactly 1 cycle):
  - m_adr = latched adr; m_wdat = latched wdat.
  - m_canWrt = we; m_canRd = ~we.
  - Write: go to ACK. Read: load counter=MEM_LAT, go to WAIT.
- WAIT:
  - Strobes 0; counter decrements each cycle.
  - On the edge where counter==1: capture m_rdat into rdatN of the owner, go to ACK.
- ACK (1 cycle):
  - ackN=1 for the owner only.
  - At exit: last=owner, gnt=0, go to IDLE.
- Outside ISSUE: m_adr, m_wdat and the strobes are held at 0.
- rdatN holds its value until that requester's next read completes. Writes do not modify rdatN.
- Latency from req sampled in IDLE:
  - Write: ack in cycle +2.
  - Read: ack in cycle +2+MEM_LAT (cycle +3 for MEM_LAT=1).
- Minimum gap between transactions is one IDLE cycle.
- Handshake:
  - req, we, adr and wdat must stay stable until ack is seen.
  - The requester drops req in the cycle after ack. req still high at the end of that IDLE cycle is a new request.
  - req dropped before ack is a protocol violation. The latched transaction still completes and still acks.
- A request arriving while busy waits in IDLE arbitration. No queueing beyond the held req line.
- gnt is one-hot and held from ISSUE through ACK inclusive. busy matches gnt!=0.
- Never more than one ack per cycle. ack0 and ack1 are never both high.

Optional Feature:
NR_ARB_FIXED_PRIO_EN
- Defined: requester 0 always wins when both req are high; the last pointer is ignored and not implemented.
- Undefined (default): round-robin as above.

Test Plan:
1. Reset: pulse clr mid-cycle -> all outputs 0 immediately (before the next clk edge); busy=0; gnt=2'b00.
2. Single write: req0=1, we0=1, adr0=4'h3, wdat0=8'hA5.
   - ISSUE cycle: m_adr=3, m_wdat=A5, m_canWrt=1 for exactly 1 cycle.
   - ack0=1 the following cycle; rdat0 unchanged.
3. Read, MEM_LAT=1: memory model returns 8'h5C for addr 7; req1=1, we1=0, adr1=7.
   - m_canRd=1 for 1 cycle.
   - ack1 three cycles after request sampling, with rdat1=8'h5C held afterwards.
4. Contention: req0 and req1 held high continuously right after reset.
   - Service order 0,1,0,1; never both acks in one cycle.
   - With NR_ARB_FIXED_PRIO_EN: only requester 0 is served while req0 stays high.
5. Reset mid-read: assert clr during WAIT.
   - No ack; strobes 0; gnt=0.
   - A subsequent write completes with normal latency, and requester 0 wins the first tie.
6. MEM_LAT=3 read: ack arrives 5 cycles after sampling; rdat captures m_rdat from the third WAIT cycle, not earlier values.
